// File: rtl/bp_me_pkg.sv
// Shared memory-engine types: DMA-to-DRAM FSM states plus the DRAM command
// and cache DMA packet declaration macros.
`ifndef BP_ME_PKG_MACROS
`define BP_ME_PKG_MACROS
`define DECLARE_BP_DRAM_CMD_S(caddr_width_mp) typedef struct packed { logic we; logic [caddr_width_mp-1:0] addr; } bp_dram_cmd_s
`define BP_DRAM_CMD_WIDTH(caddr_width_mp) (1+(caddr_width_mp))
`define DECLARE_BSG_CACHE_DMA_PKT_S(addr_width_mp) typedef struct packed { logic write_not_read; logic [addr_width_mp-1:0] addr; } bsg_cache_dma_pkt_s
`endif

package bp_me_pkg;

  typedef enum logic [2:0] {
    e_dma_idle    = 3'd0,
    e_dma_cmd     = 3'd1,
    e_dma_rd_data = 3'd2,
    e_dma_wr_data = 3'd3,
    e_dma_wr_ack  = 3'd4
  } bp_dma_dram_state_e;

endpackage

// File: rtl/bp_cache_dma_to_dram.sv
// Bridges the L2 cache DMA port to a single-outstanding DRAM channel:
// one command, a block of beats, and a write ack before the next packet.
module bp_cache_dma_to_dram
  import bp_me_pkg::*;
 #(parameter int caddr_width_p         = 28
  ,parameter int fill_width_p          = 64
  ,parameter int block_size_in_fill_p  = 8
  ,localparam int dma_pkt_width_lp     = 1+caddr_width_p
  ,localparam int dram_cmd_width_lp    = `BP_DRAM_CMD_WIDTH(caddr_width_p)
  )
  (input  logic                          clk_i
  ,input  logic                          reset_n_i
  ,input  logic [dma_pkt_width_lp-1:0]   dma_pkt_i
  ,input  logic                          dma_pkt_v_i
  ,output logic                          dma_pkt_yumi_o
  ,output logic [fill_width_p-1:0]       dma_data_o
  ,output logic                          dma_data_v_o
  ,input  logic                          dma_data_ready_and_i
  ,input  logic [fill_width_p-1:0]       dma_data_i
  ,input  logic                          dma_data_v_i
  ,output logic                          dma_data_yumi_o
  ,output logic [dram_cmd_width_lp-1:0]  dram_cmd_o
  ,output logic                          dram_cmd_v_o
  ,input  logic                          dram_cmd_ready_and_i
  ,output logic [fill_width_p-1:0]       dram_wdata_o
  ,output logic                          dram_wdata_v_o
  ,input  logic                          dram_wdata_ready_and_i
  ,input  logic [fill_width_p-1:0]       dram_rdata_i
  ,input  logic                          dram_rdata_v_i
  ,output logic                          dram_rdata_ready_and_o
  ,input  logic                          dram_wack_v_i
  );

  localparam int cnt_w_lp    = $clog2(block_size_in_fill_p);
  localparam int offset_w_lp = $clog2(block_size_in_fill_p*fill_width_p/8);

  `DECLARE_BSG_CACHE_DMA_PKT_S(caddr_width_p);
  `DECLARE_BP_DRAM_CMD_S(caddr_width_p);

  bsg_cache_dma_pkt_s pkt_li;
  bp_dram_cmd_s       cmd_q, cmd_d;
  bp_dma_dram_state_e state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic rd_hs, wr_hs, last_beat;

  assign pkt_li    = dma_pkt_i;
  assign rd_hs     = (state_q == e_dma_rd_data) & dram_rdata_v_i & dma_data_ready_and_i;
  assign wr_hs     = (state_q == e_dma_wr_data) & dma_data_v_i & dram_wdata_ready_and_i;
  assign last_beat = (cnt_q == cnt_w_lp'(block_size_in_fill_p-1));

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_dma_idle;
      cnt_q   <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_dma_idle:    if (dma_pkt_v_i) state_d = e_dma_cmd;
      e_dma_cmd:     if (dram_cmd_ready_and_i) state_d = cmd_q.we ? e_dma_wr_data : e_dma_rd_data;
      e_dma_rd_data: if (rd_hs & last_beat) state_d = e_dma_idle;
      e_dma_wr_data: if (wr_hs & last_beat) state_d = e_dma_wr_ack;
      e_dma_wr_ack:  if (dram_wack_v_i) state_d = e_dma_idle;
      default:       state_d = e_dma_idle;
    endcase
  end

  // Block-aligned command latch and the up/wrap beat counter
  always_comb begin
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    if (state_q == e_dma_idle && dma_pkt_v_i) begin
      cmd_d.we   = pkt_li.write_not_read;
      cmd_d.addr = {pkt_li.addr[caddr_width_p-1:offset_w_lp], offset_w_lp'(0)};
    end
    if (rd_hs | wr_hs)
      cnt_d = last_beat ? '0 : cnt_q + cnt_w_lp'(1);
  end

  assign dram_cmd_o = cmd_q;

  always_comb begin
    dma_pkt_yumi_o         = 1'b0;
    dram_cmd_v_o           = 1'b0;
    dma_data_o             = '0;
    dma_data_v_o           = 1'b0;
    dram_rdata_ready_and_o = 1'b0;
    dram_wdata_o           = '0;
    dram_wdata_v_o         = 1'b0;
    dma_data_yumi_o        = 1'b0;
    unique case (state_q)
      e_dma_idle: dma_pkt_yumi_o = dma_pkt_v_i;
      e_dma_cmd:  dram_cmd_v_o   = 1'b1;
      e_dma_rd_data: begin
        dma_data_o             = dram_rdata_i;
        dma_data_v_o           = dram_rdata_v_i;
        dram_rdata_ready_and_o = dma_data_ready_and_i;
      end
      e_dma_wr_data: begin
        dram_wdata_o    = dma_data_i;
        dram_wdata_v_o  = dma_data_v_i;
        dma_data_yumi_o = wr_hs;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(dram_rdata_v_i && state_q != e_dma_rd_data))
        else $error("dram rdata valid outside read data phase");
      assert (!(dram_wack_v_i && wr_hs && last_beat))
        else $error("dram wack coincides with last write beat");
      assert (!(dram_wack_v_i && state_q != e_dma_wr_ack))
        else $error("dram wack outside write ack phase");
      assert (!(dma_data_v_i && !dma_pkt_v_i && state_q == e_dma_idle))
        else $error("stray writeback beat in idle");
    end
  end
`endif

endmodule

// File: tb/tb_bp_cache_dma_to_dram.sv
// Directed bench: reads, stalled writes, ordering, back-pressure, async
// reset mid-block, and a 2-beat instance for wrap/alignment.
module tb_bp_cache_dma_to_dram;
  import bp_me_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, rst2_n;
  logic [28:0] pkt;
  logic        pkt_v, data_rdy, dv, cmd_rdy, wdr, rv, wack;
  logic [63:0] din, rdata;

  logic        yumi, dvo, dyumi, cmd_v, wv, rrdy;
  logic [63:0] dout, wdata;
  logic [28:0] cmd;
  logic        yumi2, dvo2, dyumi2, cmd_v2, wv2, rrdy2;
  logic [63:0] dout2, wdata2;
  logic [28:0] cmd2;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  bp_cache_dma_to_dram u_dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(yumi),
    .dma_data_o(dout), .dma_data_v_o(dvo), .dma_data_ready_and_i(data_rdy),
    .dma_data_i(din), .dma_data_v_i(dv), .dma_data_yumi_o(dyumi),
    .dram_cmd_o(cmd), .dram_cmd_v_o(cmd_v), .dram_cmd_ready_and_i(cmd_rdy),
    .dram_wdata_o(wdata), .dram_wdata_v_o(wv), .dram_wdata_ready_and_i(wdr),
    .dram_rdata_i(rdata), .dram_rdata_v_i(rv), .dram_rdata_ready_and_o(rrdy),
    .dram_wack_v_i(wack));

  bp_cache_dma_to_dram #(.block_size_in_fill_p(2)) u_dut2 (
    .clk_i(clk), .reset_n_i(rst2_n),
    .dma_pkt_i(pkt), .dma_pkt_v_i(pkt_v), .dma_pkt_yumi_o(yumi2),
    .dma_data_o(dout2), .dma_data_v_o(dvo2), .dma_data_ready_and_i(data_rdy),
    .dma_data_i(din), .dma_data_v_i(dv), .dma_data_yumi_o(dyumi2),
    .dram_cmd_o(cmd2), .dram_cmd_v_o(cmd_v2), .dram_cmd_ready_and_i(cmd_rdy),
    .dram_wdata_o(wdata2), .dram_wdata_v_o(wv2), .dram_wdata_ready_and_i(wdr),
    .dram_rdata_i(rdata), .dram_rdata_v_i(rv), .dram_rdata_ready_and_o(rrdy2),
    .dram_wack_v_i(wack));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Issue a packet from IDLE and leave the DUT just past the command handshake
  task automatic issue(input logic we, input logic [27:0] addr, input logic [27:0] exp_addr);
    pkt = {we, addr}; pkt_v = 1'b1; cmd_rdy = 1'b1;
    #1 chk("pkt_yumi", yumi, 1'b1);
    chk("cmd_v_same_cycle", cmd_v, 1'b0);
    tick; pkt_v = 1'b0;
    #1 chk("cmd_v", cmd_v, 1'b1);
    chk("cmd", cmd, {we, exp_addr});
    tick;
  endtask

  task automatic rd_beats(input int first, input int n, input logic [63:0] base);
    for (int i = first; i < first + n; i++) begin
      rdata = base + 64'(i); rv = 1'b1; data_rdy = 1'b1;
      #1 chk("rd_pass_data", dout, base + 64'(i));
      chk("rd_pass_v", dvo, 1'b1);
      chk("rd_ready", rrdy, 1'b1);
      tick;
    end
    rv = 1'b0;
  endtask

  task automatic wr_beats(input int n);
    for (int i = 0; i < n; i++) begin
      din = 64'hC0 + 64'(i); dv = 1'b1; wdr = 1'b1;
      #1 chk("wr_yumi_free", dyumi, 1'b1);
      tick;
    end
    dv = 1'b0;
  endtask

  initial begin
    int beat, yumis;
    rst_n = 1'b0; rst2_n = 1'b0;
    pkt = '0; pkt_v = 0; data_rdy = 0; dv = 0; cmd_rdy = 0; wdr = 0; rv = 0; wack = 0;
    din = '0; rdata = '0;
    repeat (2) tick;
    chk("rst_yumi", yumi, 0); chk("rst_cmd_v", cmd_v, 0); chk("rst_cmd", cmd, 0);
    chk("rst_dvo", dvo, 0); chk("rst_dyumi", dyumi, 0); chk("rst_wv", wv, 0);
    chk("rst_rrdy", rrdy, 0); chk("rst_state", 64'(u_dut.state_q), 64'(e_dma_idle));
    @(negedge clk) rst_n = 1'b1;
    tick;

    // Read, no stalls
    issue(1'b0, 28'h0001234, 28'h0001200);
    rd_beats(0, 8, 64'hA0);
    chk("rd_idle", 64'(u_dut.state_q), 64'(e_dma_idle));
    #1 chk("rd_dvo_off", dvo, 0);
    tick;

    // Write with command stall then toggling wdata ready
    pkt = {1'b1, 28'h0000040}; pkt_v = 1'b1; dv = 1'b1; din = 64'hB0; cmd_rdy = 1'b0;
    tick; pkt_v = 1'b0;
    #1 chk("wr_cmd", cmd, {1'b1, 28'h0000040});
    chk("wr_no_yumi_in_cmd", dyumi, 0); chk("wr_no_wv_in_cmd", wv, 0);
    tick;
    chk("wr_cmd_hold", cmd_v, 1); chk("wr_no_yumi_stall", dyumi, 0);
    cmd_rdy = 1'b1;
    tick;
    beat = 0; yumis = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      wdr = (c % 2 == 0); din = 64'hB0 + 64'(beat); dv = 1'b1;
      #1 chk("wr_yumi", dyumi, wdr);
      if (dyumi) yumis++;
      if (wdr) begin
        chk("wr_data", wdata, 64'hB0 + 64'(beat));
        beat++;
      end
      tick;
    end
    dv = 1'b0; wdr = 1'b0;
    chk("wr_beats", 64'(beat), 8); chk("wr_yumis", 64'(yumis), 8);
    chk("wr_in_ack", 64'(u_dut.state_q), 64'(e_dma_wr_ack));
    tick; tick;
    chk("wr_wait_ack", 64'(u_dut.state_q), 64'(e_dma_wr_ack));
    wack = 1'b1; tick; wack = 1'b0;
    chk("wr_idle", 64'(u_dut.state_q), 64'(e_dma_idle));

    // Writeback then refill, pkt_v held high across both
    pkt = {1'b1, 28'h0000080}; pkt_v = 1'b1; dv = 1'b1; cmd_rdy = 1'b1; din = 64'hC0;
    tick;
    pkt = {1'b0, 28'h0000100};
    #1 chk("b2b_no_yumi_cmd", yumi, 0);
    tick;
    wr_beats(8);
    chk("b2b_no_yumi_ack", yumi, 0);
    tick;
    wack = 1'b1;
    #1 chk("b2b_no_yumi_wack", yumi, 0);
    tick; wack = 1'b0;
    #1 chk("b2b_yumi_after_ack", yumi, 1);
    tick; pkt_v = 1'b0;
    #1 chk("b2b_rd_cmd", cmd, {1'b0, 28'h0000100});
    tick;
    rd_beats(0, 8, 64'hD0);

    // Read with cache back-pressure at beat 3
    issue(1'b0, 28'h0000200, 28'h0000200);
    rd_beats(0, 3, 64'hE0);
    for (int i = 0; i < 5; i++) begin
      rdata = 64'hE3; rv = 1'b1; data_rdy = 1'b0;
      #1 chk("bp_rrdy_low", rrdy, 0);
      chk("bp_cnt_hold", 64'(u_dut.cnt_q), 3);
      tick;
    end
    rd_beats(3, 5, 64'hE0);
    chk("bp_idle", 64'(u_dut.state_q), 64'(e_dma_idle));

    // Asynchronous reset in the middle of a write block
    pkt = {1'b1, 28'h0000300}; pkt_v = 1'b1; dv = 1'b1; din = 64'hC0;
    tick; pkt_v = 1'b0;
    tick;
    wr_beats(4);
    dv = 1'b1; wdr = 1'b1;
    #1 chk("mid_wv", wv, 1);
    rst_n = 1'b0;
    #1 chk("arst_wv", wv, 0); chk("arst_dyumi", dyumi, 0); chk("arst_cmd", cmd, 0);
    chk("arst_cmd_v", cmd_v, 0); chk("arst_cnt", 64'(u_dut.cnt_q), 0);
    dv = 1'b0; wdr = 1'b0;
    tick;
    @(negedge clk) rst_n = 1'b1;
    tick;
    issue(1'b0, 28'h0000400, 28'h0000400);
    chk("post_rst_cnt", 64'(u_dut.cnt_q), 0);
    rd_beats(0, 8, 64'hF0);

    // Two-beat block: alignment to 16 bytes and counter wrap
    rst_n = 1'b0;
    @(negedge clk) rst2_n = 1'b1;
    tick;
    pkt = {1'b0, 28'hFFFFFFF}; pkt_v = 1'b1; cmd_rdy = 1'b1;
    #1 chk("w2_yumi", yumi2, 1);
    tick; pkt_v = 1'b0;
    #1 chk("w2_cmd", cmd2, {1'b0, 28'hFFFFFF0});
    tick;
    rdata = 64'h11; rv = 1'b1; data_rdy = 1'b1;
    tick;
    chk("w2_cnt_1", 64'(u_dut2.cnt_q), 1);
    rdata = 64'h12;
    #1 chk("w2_beat2", dout2, 64'h12);
    tick; rv = 1'b0;
    chk("w2_cnt_wrap", 64'(u_dut2.cnt_q), 0);
    chk("w2_idle", 64'(u_dut2.state_q), 64'(e_dma_idle));
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bp_cache_dma_to_dram.md
Name: bp_cache_dma_to_dram

Overview:
Sits directly downstream of the L2 bsg_cache DMA port in the unicore memory path. Accepts one cache DMA packet at a time (block read or block writeback) and moves the fill/evict data beats. Translates each packet into a single-outstanding DRAM transaction: one command, N data beats, plus a write acknowledge for writebacks. Keeps writeback-before-refill ordering, so it can be the only path between the L2 and the DRAM controller.

Parameters:
caddr_width_p, 28, cache DMA address width (matches the L2 caddr width).
fill_width_p, 64, data beat width (equals l2_fill_width).
block_size_in_fill_p, 8, beats per cache block (power of two, at least 2).
dma_pkt_width_lp, 1+caddr_width_p, packet width, derived, not overridable.

Ports:
clk_i  in  1  clock.
reset_n_i  in  1  asynchronous, active-low reset.
dma_pkt_i  in  dma_pkt_width_lp  {write_not_read, addr} from the cache.
dma_pkt_v_i  in  1  packet valid.
dma_pkt_yumi_o  out  1  packet consumed.
dma_data_o  out  fill_width_p  read-fill beat to the cache.
dma_data_v_o  out  1  fill beat valid.
dma_data_ready_and_i  in  1  cache can take a fill beat.
dma_data_i  in  fill_width_p  writeback beat from the cache.
dma_data_v_i  in  1  writeback beat valid.
dma_data_yumi_o  out  1  writeback beat consumed.
dram_cmd_o  out  1+caddr_width_p  {we, block-aligned addr}.
dram_cmd_v_o  out  1  command valid.
dram_cmd_ready_and_i  in  1  DRAM accepts the command.
dram_wdata_o  out  fill_width_p  write beat.
dram_wdata_v_o  out  1  write beat valid.
dram_wdata_ready_and_i  in  1  DRAM accepts the write beat.
dram_rdata_i  in  fill_width_p  read beat.
dram_rdata_v_i  in  1  read beat valid.
dram_rdata_ready_and_o  out  1  block accepts the read beat.
dram_wack_v_i  in  1  write-complete pulse (one per write command).

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low: reset_n_i low forces all state immediately.
- Reset values: state=IDLE, beat counter=0, latched packet=0. All outputs 0: every valid, yumi and ready, and dram_cmd_o.
- States: IDLE, CMD, RD_DATA, WR_DATA, WR_ACK.
- IDLE:
  - dma_pkt_yumi_o = dma_pkt_v_i.
  - On yumi, latch we and the address with the low log2(block_size_in_fill_p*fill_width_p/8) bits cleared, then go to CMD.
- CMD:
  - dram_cmd_v_o=1; dram_cmd_o is held stable from the latched registers.
  - On dram_cmd_ready_and_i, go to WR_DATA if we=1, else RD_DATA.
  - Latency: packet handshake in cycle t gives dram_cmd_v_o=1 in cycle t+1 at the earliest.
- RD_DATA (combinational pass-through, zero added latency):
  - dma_data_o = dram_rdata_i.
  - dma_data_v_o = dram_rdata_v_i.
  - dram_rdata_ready_and_o = dma_data_ready_and_i.
  - In all other states, dma_data_v_o=0 and dram_rdata_ready_and_o=0.
- WR_DATA:
  - dram_wdata_o = dma_data_i.
  - dram_wdata_v_o = dma_data_v_i.
  - dma_data_yumi_o = dma_data_v_i & dram_wdata_ready_and_i.
  - Writeback beats are never forwarded before the write command is accepted.
- Beat counter:
  - Width log2(block_size_in_fill_p).
  - Increments on each read or write beat handshake.
  - Wraps to 0 on the last beat.
  - Last read beat goes to IDLE; last write beat goes to WR_ACK.
- WR_ACK:
  - Waits for dram_wack_v_i, then goes to IDLE.
  - A wack arriving in the same cycle as the last write beat is a protocol error: assert. The DRAM must ack at least one cycle after the last beat.
- Ordering and back-pressure:
  - The next packet is accepted only in IDLE, so a refill after a writeback always sees the writeback's data committed.
  - Stalls on any ready in any state hold all latched values. No timeout.
- Simultaneous events: dma_pkt_v_i while not in IDLE is ignored (no yumi).
- Protocol assertions:
  - dram_rdata_v_i outside RD_DATA.
  - dram_wack_v_i outside WR_ACK.
  - dma_data_v_i with dma_pkt_v_i=0 in IDLE (stray writeback beat).
  - All assertions are synthesis-excluded.
- Reset mid-operation: returns to IDLE, clears the counter and drops the transaction. The surrounding system must reset the DRAM side too.

Decomposition:
- Shared package (bp_me_pkg):
  - state enum bp_dma_dram_state_e;
  - dram cmd struct macro `declare_bp_dram_cmd_s(caddr_width_p) with fields we and addr;
  - width macro `bp_dram_cmd_width(caddr_width_p).
- Packet decode reuses the bsg_cache_dma_pkt_s declaration macro.
- Sub-module: none; a single module (FSM, counter, address register) is natural. The beat counter uses the library up/wrap counter.

Test Plan:
- Read, no stalls: pkt {0, 0x0001234} → dram_cmd_o={0, 0x0001200} one cycle later. 8 rdata beats 0xA0..0xA7 appear on dma_data_o in order, same cycles; state returns to IDLE after beat 8.
- Write with DRAM stalls: pkt {1, 0x0000040}, wdata_ready toggling 1,0,1,0 → exactly 8 dma_data_yumi_o pulses matching the 8 wdata handshakes. No yumi before the cmd is accepted. wack 3 cycles after the last beat → IDLE.
- Back-to-back writeback then read, pkt_v held high → the read pkt yumi only after the wack. The read cmd follows the write cmd's 8 beats and ack.
- Read with cache back-pressure: dma_data_ready_and_i=0 for 5 cycles mid-block → dram_rdata_ready_and_o=0 for those cycles, no beat lost, counter holds at 3.
- Reset mid-write: reset_n_i low after beat 4 → all outputs 0 immediately (asynchronous). After release, a new read pkt → the cmd issues and the counter starts at 0.
- Wrap and alignment: addr 0xFFFFFFF, block_size_in_fill_p=2 → cmd addr 0xFFFFFF0, counter wraps 1→0 and the state exits after 2 beats.
